// File: rtl/axi_rdata_router.sv
// axi_rdata_router
//
// Sits on the shared AXI4 R channel behind the read-address arbiter and
// steers each data beat to the requester named by its rid (Flash, Dcache,
// Device or Icache). Every AR handshake is recorded in a small in-order
// table so each response can be checked against the outstanding request:
// is the rid the expected one, and does rlast land on the recorded arlen?
// One register stage sits between the bus and the clients.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high. A valid, once raised, holds its payload stable until it is
// accepted. Ready may depend combinationally on the other side's ready
// (rready follows the selected client's ready), but no valid ever depends
// on a ready.
//
// Ports
//   clock, reset          clock; synchronous active-high reset
//   ar_hs, ar_id, ar_len  AR handshake observed from the arbiter
//   pend_full             pending table full; arbiter must hold off AR
//   rvalid/rready, rid, rdata, rresp, rlast   AXI R channel
//   fls/dc/dev/ic_valid   per-client beat valid (one-hot)
//   fls/dc/dev/ic_ready   per-client accept
//   out_data/resp/last    registered beat payload
//   out_beat              beat index within the burst, starting at 0
//   err_id/err_len/err_ovf  sticky protocol-check flags
module axi_rdata_router #(
  parameter int         DATA_W = 64,
  parameter int         DEPTH  = 4,
  parameter logic [3:0] FLS_ID = 4'b0000,
  parameter logic [3:0] DC_ID  = 4'b0001,
  parameter logic [3:0] DEV_ID = 4'b0010,
  parameter logic [3:0] IC_ID  = 4'b0011
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ar_hs,
  input  logic [3:0]        ar_id,
  input  logic [7:0]        ar_len,
  output logic              pend_full,
  input  logic              rvalid,
  output logic              rready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  output logic              fls_valid,
  output logic              dc_valid,
  output logic              dev_valid,
  output logic              ic_valid,
  input  logic              fls_ready,
  input  logic              dc_ready,
  input  logic              dev_ready,
  input  logic              ic_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_resp,
  output logic              out_last,
  output logic [7:0]        out_beat,
  output logic              err_id,
  output logic              err_len,
  output logic              err_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    TGT_FLS = 2'd0,
    TGT_DC  = 2'd1,
    TGT_DEV = 2'd2,
    TGT_IC  = 2'd3
  } tgt_e;

  // Pending-AR table: circular buffer, contents need no reset.
  logic [3:0]    r_tab_id  [DEPTH];
  logic [7:0]    r_tab_len [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Output stage and burst beat counter.
  logic              r_stg_valid;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_last;
  logic [7:0]        r_beat;
  tgt_e              r_tgt;
  logic [7:0]        r_beat_cnt;

  logic r_err_id;
  logic r_err_len;
  logic r_err_ovf;

  logic       w_full;
  logic       w_empty;
  logic       w_known;
  tgt_e       w_tgt;
  logic       w_sel_ready;
  logic       w_acc;
  logic       w_pop;
  logic       w_push;
  logic [3:0] w_head_id;
  logic [7:0] w_head_len;
  logic       w_id_bad;
  logic       w_len_bad;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_head_id  = r_tab_id[r_rd_ptr];
  assign w_head_len = r_tab_len[r_rd_ptr];

  // Decode rid into a client; unknown rids are accepted but dropped.
  always_comb begin
    w_known = 1'b1;
    w_tgt   = TGT_FLS;
    if (rid == FLS_ID)      w_tgt = TGT_FLS;
    else if (rid == DC_ID)  w_tgt = TGT_DC;
    else if (rid == DEV_ID) w_tgt = TGT_DEV;
    else if (rid == IC_ID)  w_tgt = TGT_IC;
    else                    w_known = 1'b0;
  end

  always_comb begin
    w_sel_ready = 1'b0;
    case (r_tgt)
      TGT_FLS: w_sel_ready = fls_ready;
      TGT_DC:  w_sel_ready = dc_ready;
      TGT_DEV: w_sel_ready = dev_ready;
      TGT_IC:  w_sel_ready = ic_ready;
      default: w_sel_ready = 1'b0;
    endcase
  end

  // The stage can take a new beat when empty or draining this cycle.
  assign rready = ~r_stg_valid | w_sel_ready;
  assign w_acc  = rvalid & rready;

  // A pop frees a slot in the same cycle, so a push into a full table
  // is still honoured when it coincides with a pop.
  assign w_pop  = w_acc & rlast & ~w_empty;
  assign w_push = ar_hs & (~w_full | w_pop);

  assign w_id_bad  = w_empty | (rid != w_head_id) | ~w_known;
  assign w_len_bad = ~w_empty & (rlast != (r_beat_cnt == w_head_len));

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_tab_id[r_wr_ptr]  <= ar_id;
      r_tab_len[r_wr_ptr] <= ar_len;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stg_valid <= 1'b0;
      r_data      <= '0;
      r_resp      <= '0;
      r_last      <= 1'b0;
      r_beat      <= '0;
      r_tgt       <= TGT_FLS;
      r_beat_cnt  <= '0;
      r_err_id    <= 1'b0;
      r_err_len   <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      if (w_acc && w_known) begin
        r_stg_valid <= 1'b1;
        r_data      <= rdata;
        r_resp      <= rresp;
        r_last      <= rlast;
        r_beat      <= r_beat_cnt;
        r_tgt       <= w_tgt;
      end else if (w_sel_ready) begin
        r_stg_valid <= 1'b0;
      end
      if (w_acc) begin
        r_beat_cnt <= rlast ? 8'd0 : r_beat_cnt + 8'd1;
        if (w_id_bad)  r_err_id  <= 1'b1;
        if (w_len_bad) r_err_len <= 1'b1;
      end
      if (ar_hs && !w_push) r_err_ovf <= 1'b1;
    end
  end

  assign pend_full = w_full;
  assign fls_valid = r_stg_valid & (r_tgt == TGT_FLS);
  assign dc_valid  = r_stg_valid & (r_tgt == TGT_DC);
  assign dev_valid = r_stg_valid & (r_tgt == TGT_DEV);
  assign ic_valid  = r_stg_valid & (r_tgt == TGT_IC);
  assign out_data  = r_data;
  assign out_resp  = r_resp;
  assign out_last  = r_last;
  assign out_beat  = r_beat;
  assign err_id    = r_err_id;
  assign err_len   = r_err_len;
  assign err_ovf   = r_err_ovf;

endmodule
